// File: rtl/bus_fabric.sv
// Registered, handshaked system-bus interconnect: decodes the master address into
// NUM_SLAVES equal regions, waits for the selected slave, and reports errors.
module bus_fabric #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_SLAVES  = 4,
  parameter int                    REGION_BITS = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    TIMEOUT     = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA    = 16'hDEAD
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_read,
  input  logic                             m_write,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_err,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [REGION_BITS-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic                             s_read,
  output logic                             s_write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic                             err_valid,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  input  logic                             err_clr
);

  localparam int IDX_W = ADDR_WIDTH + 1 - REGION_BITS;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_m_rdata;
  logic                    r_m_ready;
  logic                    r_m_err;
  logic [NUM_SLAVES-1:0]   r_s_sel;
  logic [REGION_BITS-1:0]  r_s_addr;
  logic [DATA_WIDTH-1:0]   r_s_wdata;
  logic                    r_s_read;
  logic                    r_s_write;
  logic                    r_err_valid;
  logic [ADDR_WIDTH-1:0]   r_err_addr;

  logic [ADDR_WIDTH:0]     w_offset;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_mapped;
  logic                    w_sel_ready;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_accept;
  logic                    w_fail;
  logic                    w_finish;

  // An address below BASE_ADDR borrows into the top offset bit, which pushes the
  // region index far past NUM_SLAVES, so one compare covers both ends of the map.
  assign w_offset = {1'b0, m_addr} - {1'b0, BASE_ADDR};
  assign w_idx    = w_offset[ADDR_WIDTH:REGION_BITS];
  assign w_mapped = (w_idx < IDX_W'(NUM_SLAVES));

  assign w_sel_ready = |(s_ready & r_s_sel);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_s_sel[i]) w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fail   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m_read && m_write) begin
          w_fail = 1'b1;
          w_next = S_DONE;
        end else if (m_read || m_write) begin
          if (w_mapped) begin
            w_accept = 1'b1;
            w_next   = S_ACCESS;
          end else begin
            w_fail = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_fail = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_m_rdata <= '0;
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
      r_s_sel   <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_read  <= 1'b0;
      r_s_write <= 1'b0;
    end else begin
      r_m_ready <= w_fail | w_finish;
      r_m_err   <= w_fail;
      if (w_accept) begin
        r_s_sel   <= NUM_SLAVES'(1) << w_idx;
        r_s_addr  <= w_offset[REGION_BITS-1:0];
        r_s_wdata <= m_wdata;
        r_s_read  <= m_read;
        r_s_write <= m_write;
        r_cnt     <= '0;
      end else if (r_state == S_ACCESS && !w_sel_ready && !w_fail) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fail || w_finish) begin
        r_s_sel   <= '0;
        r_s_read  <= 1'b0;
        r_s_write <= 1'b0;
      end
      if (w_fail) r_m_rdata <= ERR_DATA;
      else if (w_finish && r_s_read) r_m_rdata <= w_sel_rdata;
    end
  end

  // First error since the last clear is kept; a clear coinciding with a new error yields to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_fail && (!r_err_valid || err_clr)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= m_addr;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end
  end

  assign m_rdata   = r_m_rdata;
  assign m_ready   = r_m_ready;
  assign m_err     = r_m_err;
  assign s_sel     = r_s_sel;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_read    = r_s_read;
  assign s_write   = r_s_write;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;

endmodule
